// File: rtl/rf_wb_ctrl.sv
// Writeback controller for the RV32E register array: arbitrates EXU/LSU results
// onto the single write port, tracks pending writes and offers a commit bypass.

module rf_wb_query #(
  parameter int WIDTH   = 32,
  parameter int REG_NUM = 16
) (
  input  logic [4:0]         i_rs,
  input  logic [REG_NUM-1:0] i_busy,
  input  logic               i_wen,
  input  logic [4:0]         i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  output logic               o_busy,
  output logic               o_fwd,
  output logic [WIDTH-1:0]   o_fwd_data
);
  logic w_hit;

  // x0 and out-of-range addresses never match, so they read as not busy.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 1; i < REG_NUM; i++)
      if (i_rs == 5'(i)) w_hit = i_busy[i];
  end

  assign o_fwd      = i_wen && (i_waddr == i_rs) && (i_rs != 5'd0);
  assign o_busy     = w_hit && !o_fwd;
  assign o_fwd_data = i_wdata;
endmodule

module rf_wb_ctrl #(
  parameter int WIDTH   = 32,
  parameter int REG_NUM = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [4:0]       exu_rd,
  input  logic [WIDTH-1:0] exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rs1_fwd,
  output logic             rs2_fwd,
  output logic [WIDTH-1:0] rs1_fwd_data,
  output logic [WIDTH-1:0] rs2_fwd_data,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             err_rd
);
  logic               w_lsu_acc, w_exu_acc, w_acc;
  logic [4:0]         w_rd;
  logic [WIDTH-1:0]   w_data;
  logic               w_rd_zero, w_rd_bad, w_commit, w_wen;
  logic [REG_NUM-1:0] w_set, w_clr, w_busy_vis;

  logic               r_wen;
  logic [4:0]         r_waddr;
  logic [WIDTH-1:0]   r_wdata;
  logic               r_err;
  logic [REG_NUM-1:0] r_busy;

  assign lsu_ready = !rst;
  assign exu_ready = !rst && !lsu_valid;

  assign w_lsu_acc = lsu_valid && lsu_ready;
  assign w_exu_acc = exu_valid && exu_ready;
  assign w_acc     = w_lsu_acc || w_exu_acc;
  assign w_rd      = w_lsu_acc ? lsu_rd   : exu_rd;
  assign w_data    = w_lsu_acc ? lsu_data : exu_data;
  assign w_rd_zero = (w_rd == 5'd0);
  assign w_rd_bad  = (32'(w_rd) >= REG_NUM);
  assign w_commit  = w_acc && !w_rd_zero && !w_rd_bad;

  // Reset masks the registered port so a write in flight at reset never lands.
  assign w_wen = r_wen && !rst;

  for (genvar i = 0; i < REG_NUM; i++) begin : g_sb
    if (i == 0) begin : g_x0
      assign w_set[i] = 1'b0;
      assign w_clr[i] = 1'b0;
    end else begin : g_rn
      assign w_set[i] = issue_valid && (issue_rd == 5'(i));
      assign w_clr[i] = w_wen && (r_waddr == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_busy  <= '0;
    end else begin
      r_wen <= w_commit;
      if (w_commit) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
      if (w_acc && w_rd_bad) r_err <= 1'b1;
      // Set after clear: a younger producer re-marks the register busy.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign rf_wen     = w_wen;
  assign rf_waddr   = rst ? 5'd0 : r_waddr;
  assign rf_wdata   = rst ? '0 : r_wdata;
  assign err_rd     = r_err && !rst;
  assign w_busy_vis = rst ? '0 : r_busy;

  logic [1:0][4:0]       w_rs;
  logic [1:0]            w_q_busy, w_q_fwd;
  logic [1:0][WIDTH-1:0] w_q_data;

  assign w_rs = {rs2, rs1};

  for (genvar q = 0; q < 2; q++) begin : g_q
    rf_wb_query #(.WIDTH(WIDTH), .REG_NUM(REG_NUM)) u_q (
      .i_rs       (w_rs[q]),
      .i_busy     (w_busy_vis),
      .i_wen      (w_wen),
      .i_waddr    (r_waddr),
      .i_wdata    (r_wdata),
      .o_busy     (w_q_busy[q]),
      .o_fwd      (w_q_fwd[q]),
      .o_fwd_data (w_q_data[q])
    );
  end

  assign rs1_busy     = w_q_busy[0];
  assign rs2_busy     = w_q_busy[1];
  assign rs1_fwd      = w_q_fwd[0];
  assign rs2_fwd      = w_q_fwd[1];
  assign rs1_fwd_data = w_q_data[0];
  assign rs2_fwd_data = w_q_data[1];
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Writeback controller on the write side of the RV32E general-purpose register array. It accepts retiring results from two producers, EXU and LSU, through valid/ready handshakes, and arbitrates between them. It drives the array's single write port (enable, destination register, data) from registered outputs. It also keeps a per-register busy scoreboard and provides a commit-cycle bypass for operand reads.

Parameters:
WIDTH, 32, data width of a register
REG_NUM, 16, number of architectural registers (RV32E)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
exu_valid  in  1  EXU writeback request
exu_ready  out  1  EXU request accepted this cycle when high with exu_valid
exu_rd  in  5  EXU destination register
exu_data  in  WIDTH  EXU result
lsu_valid  in  1  LSU writeback request
lsu_ready  out  1  LSU request accepted this cycle when high with lsu_valid
lsu_rd  in  5  LSU destination register
lsu_data  in  WIDTH  LSU load result
issue_valid  in  1  an instruction with destination issue_rd is issuing
issue_rd  in  5  destination of the issuing instruction
rs1  in  5  operand-1 query address
rs2  in  5  operand-2 query address
rs1_busy  out  1  rs1 has a pending, uncommitted write
rs2_busy  out  1  rs2 has a pending, uncommitted write
rs1_fwd  out  1  rs1 is being committed this cycle; use rs1_fwd_data
rs2_fwd  out  1  same for rs2
rs1_fwd_data  out  WIDTH  data for rs1, valid when rs1_fwd is high
rs2_fwd_data  out  WIDTH  data for rs2, valid when rs2_fwd is high
rf_wen  out  1  write enable to the register array
rf_waddr  out  5  write register
rf_wdata  out  WIDTH  write data
err_rd  out  1  sticky flag: a request targeted rd >= REG_NUM

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, err_rd=0.
  - All busy bits are cleared.
  - exu_ready=0 and lsu_ready=0.
  - Any in-flight request is discarded and never committed.
- Arbitration (combinational readies, fixed priority, LSU highest):
  - lsu_ready = !rst.
  - exu_ready = !rst && !lsu_valid.
  - At most one request is accepted per cycle. A stalled EXU holds its valid, rd and data stable.
- Accept to commit latency is 1 cycle:
  - A request accepted in cycle N appears on rf_wen/rf_waddr/rf_wdata in cycle N+1.
  - The register array writes it at the end of cycle N+1.
  - If nothing is accepted in cycle N, rf_wen=0 in cycle N+1; rf_waddr/rf_wdata hold their previous values.
- Accepted rd=0: rf_wen=0, no scoreboard change, request consumed. x0 is never written and never busy.
- Accepted rd >= REG_NUM (16..31): rf_wen=0, request consumed, err_rd set to 1 and held until rst.
- Scoreboard: busy[REG_NUM] bits.
  - Set: busy[issue_rd] is set at posedge when issue_valid is high, 0 < issue_rd < REG_NUM.
  - Clear: busy[rf_waddr] is cleared at posedge when rf_wen is high.
  - Same register set and cleared in the same cycle: set wins, because the new producer is younger.
  - issue_rd=0 or issue_rd >= REG_NUM is ignored.
- Query outputs (combinational), for rsX in {rs1, rs2}:
  - rsX_fwd = rf_wen && rf_waddr==rsX && rsX!=0.
  - rsX_fwd_data = rf_wdata.
  - rsX_busy = busy[rsX] && !rsX_fwd.
  - rsX=0 or rsX >= REG_NUM: busy=0, fwd=0.
- The scoreboard is not a counter. The design is single-issue and in-order, so a second issue to a register that is already busy simply keeps its busy bit set.

Test Plan:
1. Reset, then idle: drive rst=1 for 2 cycles, then release → rf_wen=0, both readies go to 1 the cycle after release, all busy=0, err_rd=0.
2. EXU single write: issue_valid, issue_rd=5 in cycle 0 → rs1=5 shows busy=1 from cycle 1. exu_valid, rd=5, data=0xDEADBEEF accepted in cycle 2 → cycle 3 shows rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rs1_fwd=1, rs1_busy=0. Cycle 4 shows busy=0, rf_wen=0.
3. Collision: exu_valid(rd=3, 0x11) and lsu_valid(rd=4, 0x22) in the same cycle → lsu_ready=1, exu_ready=0. The LSU write commits next cycle. The EXU is held, accepted one cycle later and commits the following cycle. The write order is 4, then 3.
4. x0 and illegal rd: LSU rd=0, data 0xFFFFFFFF → rf_wen stays 0 and err_rd=0. EXU rd=20 → rf_wen stays 0, err_rd=1 and stays 1 across 10 idle cycles.
5. Set/clear race: register 7 commits (rf_wen=1, rf_waddr=7) in the same cycle that issue_valid, issue_rd=7 → busy[7]=1 the next cycle.
6. Reset mid-flight: accept EXU rd=9 in cycle N and assert rst in cycle N+1 → no write to register 9 is observed (rf_wen=0 from cycle N+2 on), busy[9]=0.
